// File: rtl/fetch_pc_unit.sv
// Program counter and next-PC selection for the single-cycle core.
// Adds a one-cycle boot bubble, stall hold and a retired-instruction count.
module fetch_pc_unit #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              is_j_jal,
    input  logic              is_jr,
    input  logic              is_bne,
    input  logic              is_blt,
    input  logic              is_bex,
    input  logic              alu_ne,
    input  logic              alu_lt,
    input  logic              rstatus_nz,
    input  logic [16:0]       imm17,
    input  logic [26:0]       target27,
    input  logic [31:0]       jr_target,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       link_addr,
    output logic              instr_valid,
    output logic [31:0]       instr_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] br_target;
    logic [31:0]       br_sum;
    logic              advance;
    logic              unused;

    assign pc_plus1  = pc + ADDR_W'(1);
    assign imem_addr = pc;
    assign link_addr = 32'(pc_plus1);

    // Offset added at full width, then silently wrapped to the address space.
    assign br_sum    = 32'(pc_plus1) + {{15{imm17[16]}}, imm17};
    assign br_target = br_sum[ADDR_W-1:0];

    assign unused = ^{jr_target[31:ADDR_W], target27[26:ADDR_W],
                      br_sum[31:ADDR_W]};

    always_comb begin
        next_pc = pc_plus1;
        priority case (1'b1)
            is_jr:                next_pc = jr_target[ADDR_W-1:0];
            is_j_jal:             next_pc = target27[ADDR_W-1:0];
            is_bex && rstatus_nz: next_pc = target27[ADDR_W-1:0];
            is_bne && alu_ne:     next_pc = br_target;
            is_blt && alu_lt:     next_pc = br_target;
            default:              next_pc = pc_plus1;
        endcase
    end

    always_comb begin
        state_next  = state;
        instr_valid = 1'b0;
        advance     = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN, HOLD: begin
                instr_valid = ~stall;
                advance     = ~stall;
                state_next  = stall ? HOLD : RUN;
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (advance) begin
                pc          <= next_pc;
                instr_count <= instr_count + 32'd1;
            end
        end
    end

endmodule
